fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end between the memory controller and dispatch. A run-ahead refill engine streams words into a direct-mapped instruction cache. A lookup stage pushes hits into an instruction queue drained by dispatch over a valid/ready handshake. ROB commit-time redirects flush and restart the unit. Optionally, static prediction follows JAL and backward branches.

## Interface
Parameters:
- ADDR_W, 32, address width
- INST_W, 32, instruction width
- CACHE_IDX_W, 8, cache index bits; 2^CACHE_IDX_W one-word lines, index = addr[CACHE_IDX_W+1:2], tag = addr[ADDR_W-1:CACHE_IDX_W+2]
- IQ_DEPTH, 4, instruction queue entries, power of 2, ≥2
- LOOKAHEAD, 16, max words mem_pc may run ahead of pc
- RESET_PC, 0, start address

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low all state holds
- redirect_valid  in  1  ROB commit redirect
- redirect_pc  in  ADDR_W  redirect target
- mc_req  out  1  one-cycle fetch request pulse
- mc_addr  out  ADDR_W  request address
- mc_drop  out  1  abandon any outstanding request
- mc_ok  in  1  requested word valid
- mc_data  in  INST_W  returned word
- out_valid  out  1  queue head valid
- out_ready  in  1  dispatch accepts head
- out_inst  out  INST_W  head instruction
- out_pc  out  ADDR_W  head pc
- out_pred_taken  out  1  head was predicted taken

## Operation
- Priority: rst > !rdy (full hold, no pulses change) > redirect_valid > normal.
- Reset: pc = mem_pc = RESET_PC, refill state IDLE, all cache valid bits 0, queue empty; mc_req = mc_drop = 0, mc_addr = 0, out_valid = 0, out_pred_taken = 0.
- Refill FSM:
  - IDLE: if mem_pc − pc < 4·LOOKAHEAD (unsigned, modulo 2^ADDR_W) → mc_req = 1 for one cycle, mc_addr = mem_pc, go to WAIT; otherwise stay IDLE with mc_req = 0.
  - WAIT: on mc_ok, write valid/tag/data at the mem_pc index, mem_pc += 4, go to IDLE.
- Lookup: hit = valid[idx(pc)] && tag match. If hit and queue count < IQ_DEPTH, push {pc, inst, pred}, pc ← next_pc. No push on miss or full queue.
- Queue: circular buffer with wrapping pointers and a count. Pop when out_valid && out_ready. Push and pop may occur in the same cycle; a full queue still refuses the push that cycle (no bypass).
- Redirect: queue flushed, pc = mem_pc = redirect_pc, FSM → IDLE, mc_req = 0, mc_drop = 1 for exactly one cycle. Any mc_ok in that cycle is discarded. Cache contents retained.
- Local (predicted) redirect: only with FETCH_PREDICT_EN; see Configuration.

## Timing
- Hit latency: pc hits in cycle t → out_valid with that entry at t+1, provided the queue was empty.
- Sustained throughput: one instruction per cycle on hits when out_ready is held high.
- Miss path:
  - IDLE at t → mc_req at t+1.
  - mc_ok at t+k → line valid at t+k+1.
  - Lookup hits at t+k+1 → out_valid at t+k+2.
- Refill throughput: one request per two cycles minimum, since IDLE and WAIT each take at least one cycle.
- Redirect at t:
  - mc_drop high during t+1 only.
  - First new mc_req at t+2.
  - out_valid low from t+1 until a hit at the new pc.
- mc_ok with the FSM in IDLE is ignored.

## Configuration
- FETCH_PREDICT_EN defined:
  - On a hit, decode the fetched word.
  - opcode 1101111 (JAL): next_pc = pc + J-imm, pred = 1.
  - opcode 1100011 with inst[31] = 1 (backward branch): next_pc = pc + B-imm, pred = 1.
  - Otherwise next_pc = pc + 4, pred = 0.
  - Predicted taken: mem_pc ← next_pc, FSM → IDLE. If the FSM was in WAIT, pulse mc_drop for one cycle; mc_ok that cycle is ignored.
- FETCH_PREDICT_EN undefined: next_pc = pc + 4 always, out_pred_taken tied 0, no local redirects.

## Test plan
- Cold start: RESET_PC = 0; memory returns 0x00000013 after 3 cycles → mc_addr 0, 4, 8, … in sequence; out_pc 0, 4, 8 in order, out_inst 0x00000013.
- Back-pressure: out_ready = 0, IQ_DEPTH = 4 → exactly 4 entries held with out_valid = 1. Refill stops once mem_pc − pc = 64. Releasing out_ready drains in order with no loss or duplicates.
- Redirect mid-WAIT: redirect_pc = 0x100 while a request is outstanding → mc_drop pulses one cycle, the queue empties, and the late mc_ok is not cached. Next mc_addr = 0x100.
- Cache reuse: run 0x0–0x1C, then redirect to 0x0 → out_valid asserts 2 cycles after the redirect with no new mc_req for 0x0.
- Redirect coinciding with pop and push → queue is empty next cycle and the redirect wins.
- FETCH_PREDICT_EN: 0x10 holds 0xFE000EE3 (beq x0, x0, −4) → entry has out_pred_taken = 1 and the next out_pc is 0x0C. Without the macro, the next out_pc is 0x14.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, memory-controller and dispatch signals of the fetch unit
//
// Ports (signals carried by the interface):
//   redirect_valid, redirect_pc    commit-time redirect from the ROB
//   mc_req, mc_addr, mc_drop       fetch request / abandon towards the memory controller
//   mc_ok, mc_data                 returned word from the memory controller
//   out_valid, out_ready           queue-head handshake towards dispatch
//   out_inst, out_pc, out_pred_taken  queue-head payload
// Modports: master = fetch unit side, slave = environment side.

interface fetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              mc_req;
   logic [ADDR_W-1:0] mc_addr;
   logic              mc_drop;
   logic              mc_ok;
   logic [INST_W-1:0] mc_data;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;
   logic              out_pred_taken;

   modport master (
      input  redirect_valid, redirect_pc, mc_ok, mc_data, out_ready,
      output mc_req, mc_addr, mc_drop, out_valid, out_inst, out_pc, out_pred_taken
   );

   modport slave (
      output redirect_valid, redirect_pc, mc_ok, mc_data, out_ready,
      input  mc_req, mc_addr, mc_drop, out_valid, out_inst, out_pc, out_pred_taken
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end: run-ahead refill, direct-mapped I-cache, instruction queue
//
// Optional feature macro: FETCH_PREDICT_EN (static prediction of JAL and backward branches).
// Ports:
//   clk            clock
//   rst            synchronous, active-high reset
//   rdy            global enable; when low every register holds its value
//   bus (master)   redirect_valid/redirect_pc      commit redirect in
//                  mc_req/mc_addr/mc_drop          request pulse, address, abandon pulse out
//                  mc_ok/mc_data                   returned word in
//                  out_valid/out_ready             queue head handshake
//                  out_inst/out_pc/out_pred_taken  queue head payload

module fetch_unit #(
   parameter int                ADDR_W      = 32,
   parameter int                INST_W      = 32,
   parameter int                CACHE_IDX_W = 8,
   parameter int                IQ_DEPTH    = 4,
   parameter int                LOOKAHEAD   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input logic          clk,
   input logic          rst,
   input logic          rdy,
   fetch_unit_if.master bus
);

   localparam int LINES = 1 << CACHE_IDX_W;
   localparam int TAG_W = ADDR_W - CACHE_IDX_W - 2;
   localparam int PTR_W = $clog2(IQ_DEPTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [ADDR_W-1:0] WORD     = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] WINDOW   = ADDR_W'(4 * LOOKAHEAD);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(IQ_DEPTH);

   // architectural / control state
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mem_pc;
   logic [0:0]        state;
   logic              mc_req_r;
   logic [ADDR_W-1:0] mc_addr_r;
   logic              mc_drop_r;

   // cache: only the valid bits need a reset
   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [INST_W-1:0] data_mem [LINES];

   // instruction queue
   logic [ADDR_W-1:0] q_pc   [IQ_DEPTH];
   logic [INST_W-1:0] q_inst [IQ_DEPTH];
   logic [IQ_DEPTH-1:0] q_pred;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;

   // lookup
   logic [CACHE_IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0]       pc_tag;
   logic [CACHE_IDX_W-1:0] mem_idx;
   logic [TAG_W-1:0]       mem_tag;
   logic                   hit;
   logic [INST_W-1:0]      fetched;
   logic                   q_nonempty;
   logic                   q_full;
   logic                   push;
   logic                   pop;
   logic                   can_issue;
   logic [ADDR_W-1:0]      next_pc;
   logic                   pred;
   logic                   local_redirect;
   logic                   fill_en;
   logic                   q_wr;

   assign pc_idx  = pc[CACHE_IDX_W+1:2];
   assign pc_tag  = pc[ADDR_W-1:CACHE_IDX_W+2];
   assign mem_idx = mem_pc[CACHE_IDX_W+1:2];
   assign mem_tag = mem_pc[ADDR_W-1:CACHE_IDX_W+2];

   assign hit     = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign fetched = data_mem[pc_idx];

   assign q_nonempty = (count != '0);
   assign q_full     = (count == CNT_FULL);
   // a full queue refuses the push even when the head leaves this cycle
   assign push       = hit && !q_full;
   assign pop        = q_nonempty && bus.out_ready;

   // modulo distance keeps the window test correct across address wrap
   assign can_issue = (mem_pc - pc) < WINDOW;

`ifdef FETCH_PREDICT_EN
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [ADDR_W-1:0] j_imm;
   logic [ADDR_W-1:0] b_imm;

   assign j_imm = {{(ADDR_W-21){fetched[31]}}, fetched[31], fetched[19:12],
                   fetched[20], fetched[30:21], 1'b0};
   assign b_imm = {{(ADDR_W-13){fetched[31]}}, fetched[31], fetched[7],
                   fetched[30:25], fetched[11:8], 1'b0};

   always_comb begin
      next_pc = pc + WORD;
      pred    = 1'b0;
      if (fetched[6:0] == OP_JAL) begin
         next_pc = pc + j_imm;
         pred    = 1'b1;
      end else if (fetched[6:0] == OP_BRANCH && fetched[31]) begin
         next_pc = pc + b_imm;
         pred    = 1'b1;
      end
   end
`else
   assign next_pc = pc + WORD;
   assign pred    = 1'b0;
`endif

   // only an entry that actually enters the queue steers the refill engine
   assign local_redirect = push && pred;

   assign fill_en = !rst && rdy && !bus.redirect_valid && !local_redirect
                    && (state == ST_WAIT) && bus.mc_ok;
   assign q_wr    = !rst && rdy && !bus.redirect_valid && push;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         mem_pc    <= RESET_PC;
         state     <= ST_IDLE;
         valid     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         mc_req_r  <= 1'b0;
         mc_addr_r <= '0;
         mc_drop_r <= 1'b0;
      end else if (rdy) begin
         mc_req_r  <= 1'b0;
         mc_drop_r <= 1'b0;
         if (bus.redirect_valid) begin
            // commit redirect: flush everything in flight, keep the cache
            pc        <= bus.redirect_pc;
            mem_pc    <= bus.redirect_pc;
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mc_drop_r <= 1'b1;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_ONE;
               pc     <= next_pc;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
               count <= count + CNT_ONE;
            end else if (pop && !push) begin
               count <= count - CNT_ONE;
            end

            if (local_redirect) begin
               // refill restarts at the predicted target; any return this cycle is dropped
               mem_pc    <= next_pc;
               state     <= ST_IDLE;
               mc_drop_r <= (state == ST_WAIT);
            end else if (state == ST_IDLE) begin
               if (can_issue) begin
                  mc_req_r  <= 1'b1;
                  mc_addr_r <= mem_pc;
                  state     <= ST_WAIT;
               end
            end else begin
               if (bus.mc_ok) begin
                  valid[mem_idx] <= 1'b1;
                  mem_pc         <= mem_pc + WORD;
                  state          <= ST_IDLE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[mem_idx]  <= mem_tag;
         data_mem[mem_idx] <= bus.mc_data;
      end
      if (q_wr) begin
         q_pc[wr_ptr]   <= pc;
         q_inst[wr_ptr] <= fetched;
         q_pred[wr_ptr] <= pred;
      end
   end

   assign bus.mc_req         = mc_req_r;
   assign bus.mc_addr        = mc_addr_r;
   assign bus.mc_drop        = mc_drop_r;
   assign bus.out_valid      = q_nonempty;
   assign bus.out_inst       = q_inst[rd_ptr];
   assign bus.out_pc         = q_pc[rd_ptr];
   assign bus.out_pred_taken = q_nonempty && q_pred[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(32), .INST_W(32)) dif ();

   fetch_unit u_dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (dif.master)
   );

   int vec = 0;
   int errs = 0;
   int cyc;

   bit          model_en;
   int          data_mode;
   logic        mdl_ok;
   logic [31:0] mdl_data;
   logic        man_ok;
   logic [31:0] man_data;

   assign dif.mc_ok   = model_en ? mdl_ok   : man_ok;
   assign dif.mc_data = model_en ? mdl_data : man_data;

   logic [31:0] req_log [$];
   logic [31:0] pop_pc [$];
   logic [31:0] pop_inst [$];
   bit          pop_pred [$];

   bit          pend;
   int          cnt;
   logic [31:0] paddr;

   // mode 0: every word is addi x0,x0,0; mode 1: address-tagged addi words;
   // mode 2: as mode 1 but 0x10 holds beq x0,x0,-4
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (data_mode == 0) return 32'h0000_0013;
      if (data_mode == 2 && a == 32'h10) return 32'hFE00_0EE3;
      return {a[19:0], 12'h013};
   endfunction

   // memory responder (3-cycle latency) and transaction monitor, half a cycle from the active edge
   initial begin
      mdl_ok = 1'b0; mdl_data = '0; pend = 1'b0; cnt = 0; paddr = '0; cyc = 0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (rst) begin
            pend   = 1'b0;
            mdl_ok = 1'b0;
            req_log.delete();
            pop_pc.delete();
            pop_inst.delete();
            pop_pred.delete();
         end else if (rdy) begin
            if (dif.mc_req) req_log.push_back(dif.mc_addr);
            if (dif.out_valid && dif.out_ready) begin
               pop_pc.push_back(dif.out_pc);
               pop_inst.push_back(dif.out_inst);
               pop_pred.push_back(dif.out_pred_taken);
            end
            mdl_ok = 1'b0;
            if (dif.mc_drop) pend = 1'b0;
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  mdl_ok   = 1'b1;
                  mdl_data = mem_word(paddr);
                  pend     = 1'b0;
               end
            end
            if (dif.mc_req) begin
               pend  = 1'b1;
               cnt   = 3;
               paddr = dif.mc_addr;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1;
      dif.redirect_valid = 1'b0; dif.redirect_pc = '0; dif.out_ready = 1'b0;
      man_ok = 1'b0; man_data = '0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; model_en = 1'b0; data_mode = 0;
      dif.redirect_valid = 1'b0; dif.redirect_pc = '0; dif.out_ready = 1'b0;
      man_ok = 1'b0; man_data = '0;
      repeat (2) tick();
      vec++; if (dif.mc_req !== 1'b0) begin errs++; $display("FAIL reset_mc_req: got %b expected 0", dif.mc_req); end
      vec++; if (dif.mc_drop !== 1'b0) begin errs++; $display("FAIL reset_mc_drop: got %b expected 0", dif.mc_drop); end
      vec++; if (dif.mc_addr !== 32'h0) begin errs++; $display("FAIL reset_mc_addr: got %h expected 0", dif.mc_addr); end
      vec++; if (dif.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", dif.out_valid); end
      vec++; if (dif.out_pred_taken !== 1'b0) begin errs++; $display("FAIL reset_pred: got %b expected 0", dif.out_pred_taken); end
      rst = 1'b0;
   endtask

   task automatic test_cold_start();
      int n;
      do_reset();
      data_mode = 0; model_en = 1'b1; dif.out_ready = 1'b1;
      n = 0;
      while (!dif.out_valid && n < 100) begin tick(); n++; end
      vec++; if (n != 6) begin errs++; $display("FAIL cold_first_valid_cycle: got %0d expected 6", n); end
      n = 0;
      while (pop_pc.size() < 3 && n < 200) begin tick(); n++; end
      vec++;
      if (pop_pc.size() < 3 || req_log.size() < 3) begin
         errs++; $display("FAIL cold_timeout: got %0d pops expected 3", pop_pc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (req_log[i] !== 32'(4 * i) || pop_pc[i] !== 32'(4 * i) || pop_inst[i] !== 32'h13) begin
               errs++;
               $display("FAIL cold_seq[%0d]: got addr %h pc %h inst %h expected %h %h 00000013",
                        i, req_log[i], pop_pc[i], pop_inst[i], 32'(4 * i), 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_rdy_hold();
      bit bad;
      do_reset();
      model_en = 1'b0;
      tick();
      vec++; if (dif.mc_req !== 1'b1 || dif.mc_addr !== 32'h0) begin errs++; $display("FAIL first_req: got %b/%h expected 1/0", dif.mc_req, dif.mc_addr); end
      rdy = 1'b0; man_ok = 1'b1; man_data = 32'hBAD0_0013;
      bad = 1'b0;
      repeat (3) begin
         tick();
         if (dif.mc_req !== 1'b1) bad = 1'b1;
      end
      vec++; if (bad) begin errs++; $display("FAIL rdy_hold_req: got %b expected 1 held", dif.mc_req); end
      rdy = 1'b1; man_ok = 1'b0;
      tick();
      vec++; if (dif.mc_req !== 1'b0) begin errs++; $display("FAIL rdy_release_req: got %b expected 0", dif.mc_req); end
      bad = 1'b0;
      repeat (5) begin
         tick();
         if (dif.mc_req !== 1'b0) bad = 1'b1;
      end
      vec++; if (bad) begin errs++; $display("FAIL rdy_hold_ok_ignored: got reissue 1 expected 0"); end
   endtask

   task automatic test_back_pressure();
      bit bad;
      do_reset();
      data_mode = 1; model_en = 1'b1; dif.out_ready = 1'b0;
      repeat (150) tick();
      vec++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h0 || dif.out_inst !== 32'h13) begin
         errs++; $display("FAIL bp_head: got %b %h %h expected 1 00000000 00000013", dif.out_valid, dif.out_pc, dif.out_inst);
      end
      vec++; if (pop_pc.size() != 0) begin errs++; $display("FAIL bp_no_pop: got %0d expected 0", pop_pc.size()); end
      vec++; if (req_log.size() != 20) begin errs++; $display("FAIL bp_req_count: got %0d expected 20", req_log.size()); end
      vec++; if (req_log.size() == 0 || req_log[req_log.size()-1] !== 32'h4C) begin
         errs++; $display("FAIL bp_last_req: got %h expected 0000004c", req_log.size() == 0 ? 32'hx : req_log[req_log.size()-1]);
      end
      dif.out_ready = 1'b1;
      repeat (16) tick();
      vec++; if (pop_pc.size() != 16) begin errs++; $display("FAIL bp_drain_count: got %0d expected 16", pop_pc.size()); end
      bad = 1'b0;
      for (int i = 0; i < pop_pc.size(); i++) begin
         if (pop_pc[i] !== 32'(4 * i) || pop_inst[i] !== mem_word(32'(4 * i))) bad = 1'b1;
      end
      vec++; if (bad) begin errs++; $display("FAIL bp_drain_order: got out-of-order or wrong data expected pc 0,4,8,..."); end
   endtask

   task automatic test_redirect_mid_wait();
      do_reset();
      model_en = 1'b0; dif.out_ready = 1'b0;
      tick();
      tick();
      dif.redirect_valid = 1'b1; dif.redirect_pc = 32'h100;
      man_ok = 1'b1; man_data = 32'hDEAD_0013;
      tick();
      dif.redirect_valid = 1'b0;
      vec++; if (dif.mc_drop !== 1'b1 || dif.mc_req !== 1'b0 || dif.out_valid !== 1'b0) begin
         errs++; $display("FAIL mw_drop: got drop %b req %b valid %b expected 1 0 0", dif.mc_drop, dif.mc_req, dif.out_valid);
      end
      tick();
      man_ok = 1'b0;
      vec++; if (dif.mc_drop !== 1'b0 || dif.mc_req !== 1'b1 || dif.mc_addr !== 32'h100) begin
         errs++; $display("FAIL mw_new_req: got drop %b req %b addr %h expected 0 1 00000100", dif.mc_drop, dif.mc_req, dif.mc_addr);
      end
      tick();
      man_ok = 1'b1; man_data = 32'h0010_0013;
      tick();
      man_ok = 1'b0;
      tick();
      vec++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h100 || dif.out_inst !== 32'h0010_0013) begin
         errs++; $display("FAIL mw_refill: got %b %h %h expected 1 00000100 00100013", dif.out_valid, dif.out_pc, dif.out_inst);
      end
      dif.redirect_valid = 1'b1; dif.redirect_pc = 32'h0;
      tick();
      dif.redirect_valid = 1'b0;
      vec++; if (dif.out_valid !== 1'b0 || dif.mc_drop !== 1'b1) begin
         errs++; $display("FAIL mw_flush: got valid %b drop %b expected 0 1", dif.out_valid, dif.mc_drop);
      end
      tick();
      vec++; if (dif.out_valid !== 1'b0 || dif.mc_req !== 1'b1 || dif.mc_addr !== 32'h0) begin
         errs++; $display("FAIL mw_late_not_cached: got valid %b req %b addr %h expected 0 1 00000000", dif.out_valid, dif.mc_req, dif.mc_addr);
      end
   endtask

   task automatic test_cache_reuse();
      int n;
      do_reset();
      data_mode = 1; model_en = 1'b1; dif.out_ready = 1'b1;
      n = 0;
      while (pop_pc.size() < 8 && n < 300) begin tick(); n++; end
      vec++; if (pop_pc.size() < 8) begin errs++; $display("FAIL reuse_warmup: got %0d pops expected 8", pop_pc.size()); end
      dif.redirect_valid = 1'b1; dif.redirect_pc = 32'h0;
      tick();
      dif.redirect_valid = 1'b0;
      vec++; if (dif.mc_drop !== 1'b1 || dif.mc_req !== 1'b0 || dif.out_valid !== 1'b0) begin
         errs++; $display("FAIL reuse_t1: got drop %b req %b valid %b expected 1 0 0", dif.mc_drop, dif.mc_req, dif.out_valid);
      end
      tick();
      vec++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h0 || dif.out_inst !== 32'h13) begin
         errs++; $display("FAIL reuse_hit: got %b %h %h expected 1 00000000 00000013", dif.out_valid, dif.out_pc, dif.out_inst);
      end
   endtask

   task automatic test_redirect_pop_push();
      tick();
      vec++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h4) begin
         errs++; $display("FAIL rpp_stream: got %b %h expected 1 00000004", dif.out_valid, dif.out_pc);
      end
      dif.redirect_valid = 1'b1; dif.redirect_pc = 32'h200;
      tick();
      dif.redirect_valid = 1'b0;
      vec++; if (dif.out_valid !== 1'b0 || dif.mc_drop !== 1'b1) begin
         errs++; $display("FAIL rpp_flush: got valid %b drop %b expected 0 1", dif.out_valid, dif.mc_drop);
      end
      tick();
      vec++; if (dif.out_valid !== 1'b0 || dif.mc_req !== 1'b1 || dif.mc_addr !== 32'h200) begin
         errs++; $display("FAIL rpp_restart: got valid %b req %b addr %h expected 0 1 00000200", dif.out_valid, dif.mc_req, dif.mc_addr);
      end
   endtask

   task automatic test_predict();
      int n;
      logic [31:0] exp5;
      logic [31:0] exp6;
      bit          exp_pred;
      do_reset();
      data_mode = 2; model_en = 1'b1; dif.out_ready = 1'b1;
      n = 0;
      while (pop_pc.size() < 7 && n < 400) begin tick(); n++; end
`ifdef FETCH_PREDICT_EN
      exp5 = 32'h0C; exp6 = 32'h10; exp_pred = 1'b1;
`else
      exp5 = 32'h14; exp6 = 32'h18; exp_pred = 1'b0;
`endif
      vec++;
      if (pop_pc.size() < 7) begin
         errs++; $display("FAIL pred_timeout: got %0d pops expected 7", pop_pc.size());
      end else begin
         vec++; if (pop_pc[4] !== 32'h10 || pop_inst[4] !== 32'hFE00_0EE3 || pop_pred[3] !== 1'b0) begin
            errs++; $display("FAIL pred_branch_entry: got %h %h prev_pred %b expected 00000010 fe000ee3 0", pop_pc[4], pop_inst[4], pop_pred[3]);
         end
         vec++; if (pop_pred[4] !== exp_pred) begin
            errs++; $display("FAIL pred_taken_flag: got %b expected %b", pop_pred[4], exp_pred);
         end
         vec++; if (pop_pc[5] !== exp5 || pop_pc[6] !== exp6) begin
            errs++; $display("FAIL pred_next_pc: got %h %h expected %h %h", pop_pc[5], pop_pc[6], exp5, exp6);
         end
      end
   endtask

   initial begin
      model_en = 1'b0; data_mode = 0;
      test_reset();
      test_cold_start();
      test_rdy_hold();
      test_back_pressure();
      test_redirect_mid_wait();
      test_cache_reuse();
      test_redirect_pop_push();
      test_predict();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
